// File: rtl/fmul_iter.sv
// Iterative IEEE-754 multiplier: radix-2 shift-add significand product, truncating normalisation,
// denormals flushed to zero, specials resolved in one cycle.
module fmul_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out
);

    localparam int E  = (N == 64) ? 11 : 8;
    localparam int M  = (N == 64) ? 52 : 23;
    localparam int W  = M + 1;
    localparam int P  = 2 * W;
    localparam int CW = $clog2(W);

    localparam logic signed [E+1:0] BIAS    = (E+2)'((1 << (E - 1)) - 1);
    localparam logic signed [E+1:0] EXP_INF = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EXP_MIN = '0;
    localparam logic [CW-1:0]       CNT_END = CW'(M);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t               state;
    logic [P-1:0]         acc;
    logic [P-1:0]         mcand;
    logic [W-1:0]         mplier;
    logic [CW-1:0]        cnt;
    logic signed [E+1:0]  exp_sum;
    logic                 sign;

    logic [E-1:0]         ea;
    logic [E-1:0]         eb;
    logic [M-1:0]         ma;
    logic [M-1:0]         mb;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                 res_nan, res_inf, res_flush;
    logic                 sign_in;
    logic signed [E+1:0]  exp_in;
    logic signed [E+1:0]  exp_fin;
    logic [M-1:0]         mant_fin;

    assign ea = a[N-2:M];
    assign eb = b[N-2:M];
    assign ma = a[M-1:0];
    assign mb = b[M-1:0];

    always_comb begin
        a_nan     = (&ea) && (|ma);
        b_nan     = (&eb) && (|mb);
        a_inf     = (&ea) && !(|ma);
        b_inf     = (&eb) && !(|mb);
        a_zero    = !(|ea) && !(|ma);
        b_zero    = !(|eb) && !(|mb);
        res_nan   = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
        res_inf   = a_inf || b_inf;
        res_flush = !(|ea) || !(|eb);
        sign_in   = a[N-1] ^ b[N-1];
        exp_in    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    // Product in [1,4): a set top bit means one extra exponent step and a one-bit-higher mantissa window.
    assign exp_fin  = exp_sum + $signed({{(E+1){1'b0}}, acc[P-1]});
    assign mant_fin = acc[P-1] ? acc[2*M:M+1] : acc[2*M-1:M];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            exp_sum   <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= sign_in;
                        if (res_nan || res_inf || res_flush) begin
                            if (res_nan)
                                out <= {sign_in, {(N-1){1'b1}}};
                            else if (res_inf)
                                out <= {sign_in, {E{1'b1}}, {M{1'b0}}};
                            else
                                out <= {sign_in, {(N-1){1'b0}}};
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc      <= '0;
                            mcand    <= {{W{1'b0}}, 1'b1, ma};
                            mplier   <= {1'b1, mb};
                            cnt      <= '0;
                            exp_sum  <= exp_in;
                            state    <= MUL;
                            in_ready <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_END)
                        state <= NORM;
                end
                NORM: begin
                    if (exp_fin >= EXP_INF)
                        out <= {sign, {E{1'b1}}, {M{1'b0}}};
                    else if (exp_fin <= EXP_MIN)
                        out <= {sign, {(N-1){1'b0}}};
                    else
                        out <= {sign, exp_fin[E-1:0], mant_fin};
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_iter.sv
// Bench for fmul_iter (N=32): directed corner cases plus random operands against an arithmetic
// reference model; checks results, latency, handshake, backpressure and mid-operation reset.
module tb_fmul_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    fmul_iter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: classify, then exact integer product of the significands, truncate, range-check.
    task automatic ref_mul(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] r, output int lat);
        logic         s;
        int           ex, ey, e;
        longint       mx, my, p, m;
        bit           x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        s      = x[31] ^ y[31];
        ex     = int'(x[30:23]);
        ey     = int'(y[30:23]);
        mx     = longint'(x[22:0]);
        my     = longint'(y[22:0]);
        x_nan  = (ex == 255) && (mx != 0);
        y_nan  = (ey == 255) && (my != 0);
        x_inf  = (ex == 255) && (mx == 0);
        y_inf  = (ey == 255) && (my == 0);
        x_zero = (ex == 0) && (mx == 0);
        y_zero = (ey == 0) && (my == 0);
        lat    = 1;
        if (x_nan || y_nan || (x_zero && y_inf) || (x_inf && y_zero))
            r = {s, 31'h7FFF_FFFF};
        else if (x_inf || y_inf)
            r = {s, 8'hFF, 23'd0};
        else if (ex == 0 || ey == 0)
            r = {s, 31'd0};
        else begin
            lat = 26;
            p = (mx + 64'h80_0000) * (my + 64'h80_0000);
            e = ex + ey - 127;
            if (p >= 64'h8000_0000_0000) begin
                m = (p / 64'h100_0000) % 64'h80_0000;
                e = e + 1;
            end else begin
                m = (p / 64'h80_0000) % 64'h80_0000;
            end
            if (e >= 255)
                r = {s, 8'hFF, 23'd0};
            else if (e <= 0)
                r = {s, 31'd0};
            else
                r = {s, e[7:0], m[22:0]};
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Runs one operation; garbage is driven on the inputs while busy, and the result can be held off.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [31:0] r;
        int          lat_exp, lat;
        ref_mul(x, y, r, lat_exp);
        wait_ready();
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 200) begin
            a = $urandom;
            b = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
        check({tag, "_out"}, 64'(out), 64'(r));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_out"}, 64'(out), 64'(r));
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        int          stale;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);

        // Directed values
        run_op("two_x_three", 32'h4000_0000, 32'h4040_0000, 0);
        run_op("one5_sq", 32'h3FC0_0000, 32'h3FC0_0000, 0);
        run_op("neg1_x_zero", 32'hBF80_0000, 32'h0000_0000, 0);
        run_op("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 0);
        run_op("nan_x_two", 32'h7FC0_0000, 32'h4000_0000, 0);
        run_op("neg_inf_x_two", 32'hFF80_0000, 32'h4000_0000, 0);
        run_op("denorm_flush", 32'h0000_1234, 32'hC000_0000, 0);
        run_op("overflow", 32'h7F00_0000, 32'h7F00_0000, 0);
        run_op("underflow", 32'h0080_0000, 32'h0080_0000, 0);
        run_op("max_mant", 32'h3FFF_FFFF, 32'hBFFF_FFFF, 0);

        // Backpressure, then an ordinary accept right after
        run_op("backpressure", 32'h4000_0000, 32'h4040_0000, 5);
        run_op("after_bp", 32'h3F80_0000, 32'h4120_0000, 0);

        // Reset in the middle of MUL
        wait_ready();
        a = 32'h4000_0000;
        b = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out", 64'(out), 64'd0);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midrst_no_stale", 64'(stale), 64'd0);
        run_op("after_rst", 32'hC0A0_0000, 32'h3E80_0000, 0);

        // Random operands, with some forced special exponents
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: x[30:23] = 8'hFF;
                1: y[30:23] = 8'h00;
                2: begin x[30:23] = 8'd1; y[30:23] = 8'd100; end
                3: begin x[30:23] = 8'd200; y[30:23] = 8'd190; end
                default: ;
            endcase
            run_op("random", x, y, (i % 15 == 0) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
